// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file writeback port arbiter.
// Includes the 3-to-8 decoder cell used to build the word-line select.
package wb_port_arbiter_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int REG_ZERO    = 0;

  typedef logic [2:0] req_idx_t;

  localparam req_idx_t WB_SRC_ALU    = 3'd0;
  localparam req_idx_t WB_SRC_LOAD   = 3'd1;
  localparam req_idx_t WB_SRC_MULDIV = 3'd2;
  localparam req_idx_t WB_SRC_CSR    = 3'd3;

  // 3-to-8 decoder cell with enable; cascaded to decode wider addresses.
  function automatic logic [7:0] dec3to8(input logic [2:0] a, input logic en);
    logic [7:0] y;
    y = 8'b0000_0000;
    if (en) begin
      y = 8'b0000_0001 << a;
    end else begin
      y = 8'b0000_0000;
    end
    return y;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ.
module wb_port_arbiter_rr_pick
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_idx_t           ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output req_idx_t           idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  int                   sum_s;

  // Rotate so bit j of rot_s is requester (ptr+j) mod NUM_REQ; lowest j wins.
  always_comb begin
    dbl_s = {req_i, req_i} >> ptr_i;
    rot_s = dbl_s[NUM_REQ-1:0];
    any_o = 1'b0;
    sum_s = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        any_o = 1'b1;
        sum_s = int'(ptr_i) + j;
      end else begin
        any_o = any_o;
      end
    end
    if (sum_s >= NUM_REQ) begin
      sum_s = sum_s - NUM_REQ;
    end else begin
      sum_s = sum_s;
    end
    idx_o = req_idx_t'(sum_s);
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = any_o && (idx_o == req_idx_t'(i));
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// several writeback sources; registered write with one-hot word-line select.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [2**ADDR_W-1:0]      wr_sel,
  output logic [2:0]                wr_src
);

  localparam int NUM_WL = 2**ADDR_W;

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("wb_port_arbiter: NUM_REQ out of range");
  end

  req_idx_t            ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_WL-1:0]   wr_sel_q, wr_sel_d;
  req_idx_t            wr_src_q, wr_src_d;

  logic [NUM_REQ-1:0]  pick_gnt_s;
  req_idx_t            pick_idx_s;
  logic                pick_any_s;
  logic                xfer_s;
  logic                addr_nz_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [NUM_WL-1:0]   sel_dec_s;

  wb_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  assign req_ready = (reset || hold) ? '0 : pick_gnt_s;
  assign xfer_s    = pick_any_s && !reset && !hold;

  // One-hot grant makes an AND-OR mux sufficient for address and data.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | (pick_gnt_s[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0);
      sel_data_s = sel_data_s | (pick_gnt_s[i] ? req_data[i*DATA_W +: DATA_W] : '0);
    end
  end

  assign addr_nz_s = (sel_addr_s != ADDR_W'(REG_ZERO));

  if (ADDR_W == 5) begin : g_dec_cells
    // Four 3-to-8 cells, each enabled by one value of the upper two bits.
    always_comb begin
      sel_dec_s = '0;
      for (int h = 0; h < 4; h++) begin
        sel_dec_s[8*h +: 8] = dec3to8(sel_addr_s[2:0], sel_addr_s[4:3] == 2'(h));
      end
    end
  end else begin : g_dec_generic
    // Fallback shift decoder for address widths without a cell mapping.
    always_comb begin
      sel_dec_s = {{(NUM_WL-1){1'b0}}, 1'b1} << sel_addr_s;
    end
  end

  // Next state: idle cycles drop the write strobe but keep address/data/source.
  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (xfer_s) begin
      ptr_d     = (pick_idx_s == req_idx_t'(NUM_REQ - 1)) ? 3'd0 : pick_idx_s + 3'd1;
      wr_en_d   = addr_nz_s;
      wr_sel_d  = addr_nz_s ? sel_dec_s : '0;
      wr_addr_d = sel_addr_s;
      wr_data_d = sel_data_s;
      wr_src_d  = pick_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer and output register stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q     <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_sel_q  <= '0;
      wr_src_q  <= 3'd0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_sel_q  <= wr_sel_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_sel  = wr_sel_q;
  assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            hold  = 1'b0;
  logic [N-1:0]    v     = '0;
  logic [AW-1:0]   a [N];
  logic [DW-1:0]   d [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [2**AW-1:0] wr_sel;
  logic [2:0]      wr_src;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int            ptr_m;
  logic          men;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic [2:0]    msrc;
  logic [31:0]   msel;
  logic [N-1:0]  last_rdy;
  int            last_g;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  wb_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .req_valid (v),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_sel    (wr_sel),
    .wr_src    (wr_src)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] vv, input int p);
    for (int k = 0; k < N; k++) begin
      if (vv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock: check combinational grant before the edge, registered outputs after.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    @(negedge clock);
    g  = (reset || hold) ? -1 : exp_grant(v, ptr_m);
    er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    last_rdy = req_ready;
    chk("req_ready", {60'd0, req_ready}, {60'd0, er});
    if (reset) begin
      ptr_m = 0; men = 1'b0; maddr = '0; mdata = '0; msrc = 3'd0; msel = '0;
    end else if (g >= 0) begin
      ptr_m = (g + 1) % N;
      maddr = a[g];
      mdata = d[g];
      msrc  = 3'(g);
      men   = (a[g] != 5'd0);
      msel  = men ? (32'd1 << a[g]) : 32'd0;
    end else begin
      men  = 1'b0;
      msel = 32'd0;
    end
    last_g = g;
    @(posedge clock);
    #1;
    chk("wr_en",   {63'd0, wr_en},   {63'd0, men});
    chk("wr_addr", {59'd0, wr_addr}, {59'd0, maddr});
    chk("wr_data", {32'd0, wr_data}, {32'd0, mdata});
    chk("wr_src",  {61'd0, wr_src},  {61'd0, msrc});
    chk("wr_sel",  {32'd0, wr_sel},  {32'd0, msel});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    ptr_m = 0; men = 1'b0; maddr = '0; mdata = '0; msrc = 3'd0; msel = '0;
    last_g = -1;
    #1;
    do_reset();
    chk("rst_wr_en",  {63'd0, wr_en}, 64'd0);
    chk("rst_wr_sel", {32'd0, wr_sel}, 64'd0);

    // Test 1: single requester
    v = 4'b0001; a[WB_SRC_ALU] = 5'd5; d[WB_SRC_ALU] = 32'hDEADBEEF;
    cycle();
    chk("t1_rdy",  {60'd0, last_rdy}, 64'h1);
    chk("t1_en",   {63'd0, wr_en}, 64'd1);
    chk("t1_addr", {59'd0, wr_addr}, 64'd5);
    chk("t1_sel",  {32'd0, wr_sel}, 64'h20);
    chk("t1_data", {32'd0, wr_data}, 64'hDEADBEEF);
    chk("t1_src",  {61'd0, wr_src}, 64'd0);
    v = 4'b0000;

    // Test 2: all valid, rotate 0..3
    do_reset();
    v = 4'b1111;
    for (int k = 0; k < N; k++) begin a[k] = 5'(k + 1); d[k] = 32'(k + 100); end
    for (int k = 0; k < N; k++) begin
      cycle();
      chk("t2_rdy",  {60'd0, last_rdy}, 64'd1 << k);
      chk("t2_addr", {59'd0, wr_addr}, 64'(k + 1));
      v[k] = 1'b0;
    end
    v = 4'b1111;
    cycle();
    chk("t2_wrap", {60'd0, last_rdy}, 64'h1);
    v = 4'b0000;

    // Test 3: write to r0 retires but does not write
    do_reset();
    v = 4'b0100; a[WB_SRC_MULDIV] = 5'd0; d[WB_SRC_MULDIV] = 32'h1234;
    cycle();
    chk("t3_rdy",  {60'd0, last_rdy}, 64'h4);
    chk("t3_en",   {63'd0, wr_en}, 64'd0);
    chk("t3_sel",  {32'd0, wr_sel}, 64'd0);
    chk("t3_data", {32'd0, wr_data}, 64'h1234);
    v = 4'b0000;

    // Test 4: hold freezes grants; ptr is 3 afterwards
    v = 4'b1111;
    for (int k = 0; k < N; k++) a[k] = 5'(k + 1);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_rdy", {60'd0, last_rdy}, 64'd0);
      chk("t4_en",  {63'd0, wr_en}, 64'd0);
    end
    hold = 1'b0;
    cycle();
    chk("t4_rel", {60'd0, last_rdy}, 64'h8);
    chk("t4_addr", {59'd0, wr_addr}, 64'd4);
    v = 4'b0000;

    // Test 5: same-address collision with ptr=2
    do_reset();
    v = 4'b0010; a[1] = 5'd3;
    cycle();
    v = 4'b1010; a[1] = 5'd7; d[1] = 32'hA; a[3] = 5'd7; d[3] = 32'hB;
    cycle();
    chk("t5_rdy3", {60'd0, last_rdy}, 64'h8);
    chk("t5_dat3", {32'd0, wr_data}, 64'hB);
    v[3] = 1'b0;
    cycle();
    chk("t5_rdy1", {60'd0, last_rdy}, 64'h2);
    chk("t5_addr", {59'd0, wr_addr}, 64'd7);
    chk("t5_dat1", {32'd0, wr_data}, 64'hA);
    v = 4'b0000;

    // Test 6: reset squashes an in-flight write
    do_reset();
    v = 4'b0011; a[0] = 5'd9; a[1] = 5'd10; d[1] = 32'h55;
    cycle();
    chk("t6_rdy0", {60'd0, last_rdy}, 64'h1);
    chk("t6_en",   {63'd0, wr_en}, 64'd1);
    v[0] = 1'b0;
    reset = 1'b1;
    cycle();
    chk("t6_rst_rdy", {60'd0, last_rdy}, 64'd0);
    chk("t6_squash",  {63'd0, wr_en}, 64'd0);
    reset = 1'b0;
    cycle();
    chk("t6_rdy1", {60'd0, last_rdy}, 64'h2);
    chk("t6_addr", {59'd0, wr_addr}, 64'd10);
    v = 4'b0000;

    // Randomized traffic; requesters hold their request until granted
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          case ($urandom_range(0, 3))
            0:       a[i] = 5'd0;
            1:       a[i] = 5'(i + 1);
            default: a[i] = 5'($urandom_range(0, 31));
          endcase
          d[i] = $urandom;
        end
      end
      cycle();
      if (last_g >= 0) v[last_g] = 1'b0;
    end

    reset = 1'b0;
    hold  = 1'b0;
    v     = 4'b0000;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
